pll_lock_supervisor: RTL



---
 rtl/pll_lock_supervisor_if.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor, the PLL wrapper and the reset tree.
// master: the supervisor side. slave: the PLL and reset-tree environment.
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       restart;
  logic       pll_resetb;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [7:0] retry_count;
  logic [7:0] loss_count;

  modport master (
    input  pll_locked, restart,
    output pll_resetb, sys_rst_n, ready, fail, retry_count, loss_count
  );

  modport slave (
    output pll_locked, restart,
    input  pll_resetb, sys_rst_n, ready, fail, retry_count, loss_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences an iCE40 PLL from its reference clock: reset pulse, lock wait with timeout/retry,
// lock qualification, and downstream reset release. Every output is registered.
module pll_lock_supervisor #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1000,
  parameter int MAX_RETRIES   = 4
) (
  input  logic                  clock_in,
  input  logic                  resetn,
  pll_lock_supervisor_if.master bus
);

  localparam int MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W = (MAX_P < 2) ? 1 : $clog2(MAX_P);

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       retry, retry_nxt;
  logic [7:0]       loss, loss_nxt;
  logic             lock_p0, lock_s;
  logic             pll_resetb_q, sys_rst_n_q, ready_q, fail_q;
  logic             pll_resetb_nxt, sys_rst_n_nxt, ready_nxt, fail_nxt;

  // Lock synchronizer: pll_locked is asynchronous to clock_in
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_p0 <= bus.pll_locked;
      lock_s  <= lock_p0;
    end
  end

  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state        <= S_RESET_PLL;
      cnt          <= '0;
      retry        <= '0;
      loss         <= '0;
      pll_resetb_q <= 1'b0;
      sys_rst_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      retry        <= retry_nxt;
      loss         <= loss_nxt;
      pll_resetb_q <= pll_resetb_nxt;
      sys_rst_n_q  <= sys_rst_n_nxt;
      ready_q      <= ready_nxt;
      fail_q       <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    loss_nxt  = loss;
    cnt_nxt   = cnt;
    case (state)
      S_RESET_PLL: if (cnt == RESET_LAST) state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = S_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_nxt = retry + 8'd1;
          state_nxt = (retry_nxt == RETRY_LIMIT) ? S_FAIL : S_RESET_PLL;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_RUN;
          retry_nxt = '0;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_nxt = S_RESET_PLL;
          if (loss != 8'hFF) loss_nxt = loss + 8'd1;
        end
      end
      S_FAIL:  state_nxt = S_FAIL;
      default: state_nxt = S_RESET_PLL;
    endcase

    // restart outranks every other event and never counts as a lock loss
    if (bus.restart) begin
      state_nxt = S_RESET_PLL;
      retry_nxt = '0;
      loss_nxt  = loss;
    end

    if (bus.restart || (state_nxt != state)) begin
      cnt_nxt = '0;
    end else if ((state == S_RESET_PLL) || (state == S_WAIT_LOCK) || (state == S_STABLE)) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they register in step with it
  always_comb begin
    pll_resetb_nxt = 1'b0;
    sys_rst_n_nxt  = 1'b0;
    ready_nxt      = 1'b0;
    fail_nxt       = 1'b0;
    case (state_nxt)
      S_WAIT_LOCK, S_STABLE: pll_resetb_nxt = 1'b1;
      S_RUN: begin
        pll_resetb_nxt = 1'b1;
        sys_rst_n_nxt  = 1'b1;
        ready_nxt      = 1'b1;
      end
      S_FAIL:  fail_nxt = 1'b1;
      default: ;
    endcase
  end

  assign bus.pll_resetb  = pll_resetb_q;
  assign bus.sys_rst_n   = sys_rst_n_q;
  assign bus.ready       = ready_q;
  assign bus.fail        = fail_q;
  assign bus.retry_count = retry;
  assign bus.loss_count  = loss;

endmodule
